// File: rtl/miim_master.sv
// miim_master: MII management (MDC/MDIO) master, IEEE 802.3 clause-22 frames.
//
// Generates a free-running Mdc from Clk_reg and serialises write / read frames
// (preamble, ST/OP, PHY and register address, turnaround, data) on Mdo/MdoEn,
// capturing read data from Mdi.
//
// Ports:
//   Clk_reg, Reset          - sole clock; synchronous active-high reset
//   Divider                 - Clk_reg cycles per Mdc period (clamped, even)
//   CtrlData, Rgad, Fiad    - write data, register address, PHY address
//   NoPre                   - suppress the 32-bit preamble
//   WCtrlData, RStat        - write / read requests (levels)
//   ScanStat                - continuous scan-read request (level)
//   Mdi / Mdc, Mdo, MdoEn   - MDIO pad interface
//   Busy                    - frame in progress
//   WCtrlDataStart          - pulse: write accepted
//   RStatStart              - pulse: read accepted
//   UpdateMIIRX_DATAReg     - pulse: Prsd holds new read data
//   Prsd, LinkFail, Nvalid  - read data, link-fail status, scan not yet valid
//
// Build option: define MIIM_SCAN_EN to enable scan reads (ScanStat/Nvalid);
// without it ScanStat is ignored and Nvalid is tied low.

module miim_master #(
   parameter int unsigned PRE_LEN = 32,
   parameter int unsigned MIN_DIV = 2
) (
   input  logic        Clk_reg,
   input  logic        Reset,
   input  logic [7:0]  Divider,
   input  logic [15:0] CtrlData,
   input  logic [4:0]  Rgad,
   input  logic [4:0]  Fiad,
   input  logic        NoPre,
   input  logic        WCtrlData,
   input  logic        RStat,
   input  logic        ScanStat,
   input  logic        Mdi,
   output logic        Mdc,
   output logic        Mdo,
   output logic        MdoEn,
   output logic        Busy,
   output logic        WCtrlDataStart,
   output logic        RStatStart,
   output logic        UpdateMIIRX_DATAReg,
   output logic [15:0] Prsd,
   output logic        LinkFail,
   output logic        Nvalid
);

   localparam logic [7:0] MinDiv  = 8'(MIN_DIV);
   localparam logic [5:0] PreLast = 6'(PRE_LEN - 1);

   localparam logic [2:0] StIdle = 3'd0;
   localparam logic [2:0] StPre  = 3'd1;
   localparam logic [2:0] StStOp = 3'd2;
   localparam logic [2:0] StAddr = 3'd3;
   localparam logic [2:0] StTa   = 3'd4;
   localparam logic [2:0] StData = 3'd5;

   // ---------------------------------------------------------------------
   // Mdc generation
   // ---------------------------------------------------------------------
   logic [7:0] div_clamp;
   logic [6:0] half_new, half_q, hcnt_q;
   logic       mdc_q, wrap, rise_tick, fall_tick;
   logic       unused_div0;

   always_comb begin
      div_clamp = (Divider < MinDiv) ? MinDiv : Divider;
      half_new  = div_clamp[7:1];    // dropping the LSB forces an even divider
   end
   assign unused_div0 = div_clamp[0];

   assign wrap      = (hcnt_q == half_q - 7'd1);
   assign rise_tick = wrap & ~mdc_q;
   assign fall_tick = wrap &  mdc_q;

   // The half-period length is only reloaded at a wrap, so a Divider change
   // never produces a truncated Mdc phase.
   always_ff @(posedge Clk_reg) begin
      if (Reset) begin
         hcnt_q <= '0;
         half_q <= half_new;
         mdc_q  <= 1'b0;
      end else if (wrap) begin
         hcnt_q <= '0;
         half_q <= half_new;
         mdc_q  <= ~mdc_q;
      end else begin
         hcnt_q <= hcnt_q + 7'd1;
      end
   end

   // ---------------------------------------------------------------------
   // Frame sequencing: (state_q, cnt_q) names the bit currently on the wire
   // ---------------------------------------------------------------------
   logic [2:0]  state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        wr_q, wr_n;
   logic [9:0]  addr_q, addr_n;
   logic [15:0] data_q, data_n, shift_q, prsd_q;
   logic        mdo_q, mdoen_q, linkfail_q;
   logic        wstart_q, rstart_q, upd_q;
   logic        idle, start_wr, start_rd, start_scan, start, frame_end;
   logic [3:0]  st_op;
   logic        drv_en, drv_bit;

   assign idle     = (state_q == StIdle);
   assign start_wr = fall_tick & idle & WCtrlData;
   assign start_rd = fall_tick & idle & ~WCtrlData & RStat;
`ifdef MIIM_SCAN_EN
   assign start_scan = fall_tick & idle & ~WCtrlData & ~RStat & ScanStat;
`else
   assign start_scan = 1'b0;
`endif
   assign start     = start_wr | start_rd | start_scan;
   assign frame_end = fall_tick & (state_q == StData) & (cnt_q == 6'd15);

   // Frame parameters as seen by the bit being launched this cycle; on the
   // start edge they come straight from the inputs. NoPre only chooses the
   // first state, so it needs no register of its own.
   assign wr_n   = start ? start_wr       : wr_q;
   assign addr_n = start ? {Fiad, Rgad}   : addr_q;
   assign data_n = start ? CtrlData       : data_q;
   assign st_op  = wr_n ? 4'b0101 : 4'b0110;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (start) begin
         state_d = NoPre ? StStOp : StPre;
         cnt_d   = '0;
      end else if (fall_tick) begin
         cnt_d = cnt_q + 6'd1;
         case (state_q)
            StPre:  if (cnt_q == PreLast) begin state_d = StStOp; cnt_d = '0; end
            StStOp: if (cnt_q == 6'd3)    begin state_d = StAddr; cnt_d = '0; end
            StAddr: if (cnt_q == 6'd9)    begin state_d = StTa;   cnt_d = '0; end
            StTa:   if (cnt_q == 6'd1)    begin state_d = StData; cnt_d = '0; end
            StData: if (cnt_q == 6'd15)   begin state_d = StIdle; cnt_d = '0; end
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Level to drive for the position being entered.
   always_comb begin
      drv_en  = 1'b0;
      drv_bit = 1'b0;
      case (state_d)
         StPre: begin
            drv_en  = 1'b1;
            drv_bit = 1'b1;
         end
         StStOp: begin
            drv_en  = 1'b1;
            drv_bit = st_op[2'd3 - cnt_d[1:0]];
         end
         StAddr: begin
            drv_en  = 1'b1;
            drv_bit = addr_n[4'd9 - cnt_d[3:0]];
         end
         StTa: begin
            drv_en  = wr_n;
            drv_bit = wr_n & ~cnt_d[0];   // write turnaround is "10"
         end
         StData: begin
            drv_en  = wr_n;
            drv_bit = wr_n & data_n[4'd15 - cnt_d[3:0]];
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk_reg) begin
      if (Reset) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         shift_q    <= '0;
         prsd_q     <= '0;
         mdo_q      <= 1'b0;
         mdoen_q    <= 1'b0;
         linkfail_q <= 1'b0;
         wstart_q   <= 1'b0;
         rstart_q   <= 1'b0;
         upd_q      <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wstart_q <= start_wr;
         rstart_q <= start_rd;
         upd_q    <= frame_end & ~wr_q;
         if (start) begin
            wr_q   <= start_wr;
            addr_q <= {Fiad, Rgad};
            data_q <= CtrlData;
         end
         if (fall_tick) begin
            mdo_q   <= drv_bit;
            mdoen_q <= drv_en;
         end
         // The PHY launches read data after a rising edge; sampling at the
         // next rising edge gives a full Mdc period of setup.
         if (rise_tick && state_q == StData && !wr_q) begin
            shift_q <= {shift_q[14:0], Mdi};
         end
         if (frame_end && !wr_q) begin
            prsd_q <= shift_q;
            if (addr_q[4:0] == 5'd1) begin
               linkfail_q <= ~shift_q[2];   // PHY status bit 2 is link-up
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Scan status
   // ---------------------------------------------------------------------
`ifdef MIIM_SCAN_EN
   logic scan_q, armed_q, nvalid_q;

   // armed_q marks that the next scan is the first since ScanStat rose.
   always_ff @(posedge Clk_reg) begin
      if (Reset) begin
         scan_q   <= 1'b0;
         armed_q  <= 1'b1;
         nvalid_q <= 1'b0;
      end else begin
         if (start) scan_q <= start_scan;
         if (!ScanStat)       armed_q <= 1'b1;
         else if (start_scan) armed_q <= 1'b0;
         if (start_scan && armed_q)     nvalid_q <= 1'b1;
         else if (frame_end && scan_q)  nvalid_q <= 1'b0;
         else if (idle && !ScanStat)    nvalid_q <= 1'b0;
      end
   end

   assign Nvalid = nvalid_q;
`else
   logic unused_scan;
   assign unused_scan = ScanStat;
   assign Nvalid      = 1'b0;
`endif

   assign Mdc                 = mdc_q;
   assign Mdo                 = mdo_q;
   assign MdoEn               = mdoen_q;
   assign Busy                = ~idle;
   assign WCtrlDataStart      = wstart_q;
   assign RStatStart          = rstart_q;
   assign UpdateMIIRX_DATAReg = upd_q;
   assign Prsd                = prsd_q;
   assign LinkFail            = linkfail_q;

endmodule

// File: tb/tb_miim_master.sv
module tb_miim_master;

   logic        Clk_reg = 1'b0;
   logic        Reset = 1'b1;
   logic [7:0]  Divider = 8'd8;
   logic [15:0] CtrlData = '0;
   logic [4:0]  Rgad = '0;
   logic [4:0]  Fiad = '0;
   logic        NoPre = 1'b0;
   logic        WCtrlData = 1'b0;
   logic        RStat = 1'b0;
   logic        ScanStat = 1'b0;
   logic        Mdi = 1'b1;
   logic        Mdc, Mdo, MdoEn, Busy;
   logic        WCtrlDataStart, RStatStart, UpdateMIIRX_DATAReg;
   logic [15:0] Prsd;
   logic        LinkFail, Nvalid;

   miim_master dut (
      .Clk_reg             (Clk_reg),
      .Reset               (Reset),
      .Divider             (Divider),
      .CtrlData            (CtrlData),
      .Rgad                (Rgad),
      .Fiad                (Fiad),
      .NoPre               (NoPre),
      .WCtrlData           (WCtrlData),
      .RStat               (RStat),
      .ScanStat            (ScanStat),
      .Mdi                 (Mdi),
      .Mdc                 (Mdc),
      .Mdo                 (Mdo),
      .MdoEn               (MdoEn),
      .Busy                (Busy),
      .WCtrlDataStart      (WCtrlDataStart),
      .RStatStart          (RStatStart),
      .UpdateMIIRX_DATAReg (UpdateMIIRX_DATAReg),
      .Prsd                (Prsd),
      .LinkFail            (LinkFail),
      .Nvalid              (Nvalid)
   );

   always #5 Clk_reg = ~Clk_reg;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference frame (expected Mdo / MdoEn per Mdc period) and captured frame.
   bit eb[$], ee[$], gm[$], ge[$];
   int busy_cyc, n_wst, n_rst, n_upd, frame_bits;
   bit nv_start, scramble_en;
   logic [15:0] phy_word;
   logic [15:0] exp_prsd = '0;
   logic        exp_lf = 1'b0;

   task automatic push_exp(input bit b, input bit e);
      eb.push_back(b & e);
      ee.push_back(e);
   endtask

   task automatic build_exp(input bit wr, input bit nopre, input logic [4:0] fa,
                            input logic [4:0] ra, input logic [15:0] d);
      logic [3:0] so;
      eb.delete();
      ee.delete();
      if (!nopre) repeat (32) push_exp(1'b1, 1'b1);
      so = wr ? 4'b0101 : 4'b0110;
      for (int i = 3; i >= 0; i--) push_exp(so[i], 1'b1);
      for (int i = 4; i >= 0; i--) push_exp(fa[i], 1'b1);
      for (int i = 4; i >= 0; i--) push_exp(ra[i], 1'b1);
      push_exp(1'b1, wr);
      push_exp(1'b0, wr);
      for (int i = 15; i >= 0; i--) push_exp(d[i], wr);
      frame_bits = eb.size();
   endtask

   // PHY drives the last 16 bits of a read frame; elsewhere the line idles high.
   function automatic bit phy_bit(input int i);
      if (i >= frame_bits - 16 && i < frame_bits) return phy_word[frame_bits - 1 - i];
      return 1'b1;
   endfunction

   task automatic scramble();
      Fiad     = 5'($urandom());
      Rgad     = 5'($urandom());
      CtrlData = 16'($urandom());
      NoPre    = 1'($urandom());
   endtask

   // Watch one frame from request to Busy fall, acting as upstream register
   // file (clears requests on Start pulses) and as the PHY.
   task automatic run_frame(input int budget, input int rstat_at, input int reset_at);
      bit seen, prev, ok;
      int idx;
      seen = 0; ok = 0; idx = 0; prev = Mdc;
      gm.delete(); ge.delete();
      busy_cyc = 0; n_wst = 0; n_rst = 0; n_upd = 0; nv_start = 0;
      for (int c = 0; c < budget; c++) begin
         @(negedge Clk_reg);
         if (WCtrlDataStart) begin n_wst++; WCtrlData = 1'b0; if (scramble_en) scramble(); end
         if (RStatStart) begin n_rst++; RStat = 1'b0; if (scramble_en) scramble(); end
         if (UpdateMIIRX_DATAReg) n_upd++;
         if (Busy) begin
            if (!seen) nv_start = Nvalid;
            seen = 1;
            busy_cyc++;
         end
         if (Busy && Mdc && !prev) begin
            gm.push_back(Mdo);
            ge.push_back(MdoEn);
            idx++;
            if (idx == rstat_at) RStat = 1'b1;
            if (idx == reset_at) begin Reset = 1'b1; ok = 1; break; end
         end
         Mdi  = phy_bit(idx);
         prev = Mdc;
         if (seen && !Busy) begin ok = 1; break; end
      end
      check("frame_done", ok, 1'b1);
   endtask

   task automatic compare_frame(input string nm, input logic [7:0] div);
      logic [63:0] gv, ev, gen, een;
      bit gb, gbe;
      int eff;
      gv = '0; ev = '0; gen = '0; een = '0;
      for (int i = 0; i < eb.size(); i++) begin
         gb  = (i < gm.size()) ? gm[i] : 1'b0;
         gbe = (i < ge.size()) ? ge[i] : 1'b0;
         gv  = {gv[62:0], gb & ee[i]};
         ev  = {ev[62:0], eb[i]};
         gen = {gen[62:0], gbe};
         een = {een[62:0], ee[i]};
      end
      eff = (div < 8'd2) ? 2 : int'(div);
      eff = eff - (eff % 2);
      check({nm, "_len"},  gm.size(), eb.size());
      check({nm, "_mdo"},  gv, ev);
      check({nm, "_en"},   gen, een);
      check({nm, "_busy"}, busy_cyc, eb.size() * eff);
   endtask

   task automatic frame_test(input string nm, input bit wr, input bit nopre,
                             input logic [4:0] fa, input logic [4:0] ra,
                             input logic [15:0] d, input logic [15:0] pw,
                             input logic [7:0] div);
      Divider = div; Fiad = fa; Rgad = ra; CtrlData = d; NoPre = nopre; phy_word = pw;
      build_exp(wr, nopre, fa, ra, d);
      if (wr) WCtrlData = 1'b1;
      else    RStat = 1'b1;
      run_frame(20000, -1, -1);
      compare_frame(nm, div);
      check({nm, "_wst"}, n_wst, wr);
      check({nm, "_rst"}, n_rst, !wr);
      check({nm, "_upd"}, n_upd, !wr);
      if (!wr) begin
         exp_prsd = pw;
         if (ra == 5'd1) exp_lf = ~pw[2];
      end
      check({nm, "_prsd"}, Prsd, exp_prsd);
      check({nm, "_lf"},   LinkFail, exp_lf);
   endtask

   task automatic measure_period(output int p);
      int last, rises;
      bit prev;
      last = 0; rises = 0; prev = Mdc; p = -1;
      for (int c = 0; c < 2000; c++) begin
         @(negedge Clk_reg);
         if (Mdc && !prev) begin
            rises++;
            if (rises == 3) begin p = c - last; break; end
            last = c;
         end
         prev = Mdc;
      end
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p;
      bit wr;
      logic [4:0] ra;
      scramble_en = 1;

      // Reset state
      repeat (4) @(negedge Clk_reg);
      check("rst_mdc", Mdc, 1'b0);
      check("rst_mdo", {Mdo, MdoEn}, 2'b00);
      check("rst_busy", Busy, 1'b0);
      check("rst_pulses", {WCtrlDataStart, RStatStart, UpdateMIIRX_DATAReg}, 3'b000);
      check("rst_prsd", Prsd, 16'h0000);
      check("rst_lf_nv", {LinkFail, Nvalid}, 2'b00);
      Reset = 1'b0;

      // Mdc period and clamp
      Divider = 8'd8;
      measure_period(p);
      check("period_div8", p, 8);
      Divider = 8'd1;
      measure_period(p);
      check("period_div1", p, 2);
      Divider = 8'd5;
      measure_period(p);
      check("period_div5", p, 4);

      // Directed frames
      frame_test("wr_plan", 1'b1, 1'b0, 5'h02, 5'h01, 16'hA5C3, 16'h0000, 8'd8);
      frame_test("rd_plan", 1'b0, 1'b1, 5'h02, 5'h01, 16'h0000, 16'h7849, 8'd4);
      check("rd_plan_lf1", LinkFail, 1'b1);

      // Write and read requested together: write first, then read.
      scramble_en = 0;
      Divider = 8'd4; Fiad = 5'h11; Rgad = 5'h01; CtrlData = 16'h1234; NoPre = 1'b1;
      phy_word = 16'hFFFB;
      build_exp(1'b1, 1'b1, 5'h11, 5'h01, 16'h1234);
      WCtrlData = 1'b1; RStat = 1'b1;
      run_frame(20000, -1, -1);
      compare_frame("prio_wr", 8'd4);
      check("prio_wr_wst", n_wst, 1);
      check("prio_wr_rst", n_rst, 0);
      build_exp(1'b0, 1'b1, 5'h11, 5'h01, 16'h1234);
      run_frame(20000, -1, -1);
      compare_frame("prio_rd", 8'd4);
      check("prio_rd_rst", n_rst, 1);
      check("prio_rd_wst", n_wst, 0);
      exp_prsd = 16'hFFFB; exp_lf = 1'b1;
      check("prio_rd_prsd", Prsd, exp_prsd);
      check("prio_rd_lf", LinkFail, exp_lf);

      // Reset in the middle of a write
      Divider = 8'd2; Fiad = 5'h03; Rgad = 5'h04; CtrlData = 16'hBEEF; NoPre = 1'b0;
      build_exp(1'b1, 1'b0, 5'h03, 5'h04, 16'hBEEF);
      WCtrlData = 1'b1;
      run_frame(20000, -1, 20);
      @(negedge Clk_reg);
      check("midrst_busy", Busy, 1'b0);
      check("midrst_en_mdc", {MdoEn, Mdc}, 2'b00);
      check("midrst_pulses", {WCtrlDataStart, RStatStart, UpdateMIIRX_DATAReg}, 3'b000);
      Reset = 1'b0;
      exp_prsd = '0; exp_lf = 1'b0;
      scramble_en = 1;
      frame_test("post_rst_wr", 1'b1, 1'b0, 5'h03, 5'h04, 16'hBEEF, 16'h0000, 8'd2);

      // Randomized frames
      for (int k = 0; k < 12; k++) begin
         wr = 1'($urandom());
         ra = ($urandom_range(0, 2) == 0) ? 5'd1 : 5'($urandom());
         frame_test($sformatf("rnd%0d", k), wr, 1'($urandom()), 5'($urandom()), ra,
                    16'($urandom()), 16'($urandom()), 8'($urandom_range(0, 10)));
      end

      scramble_en = 0;
`ifdef MIIM_SCAN_EN
      Divider = 8'd2; NoPre = 1'b1; Fiad = 5'h07; Rgad = 5'h01; phy_word = 16'h786D;
      build_exp(1'b0, 1'b1, 5'h07, 5'h01, 16'h0000);
      ScanStat = 1'b1;
      run_frame(20000, -1, -1);
      compare_frame("scan1", 8'd2);
      check("scan1_nv_start", nv_start, 1'b1);
      check("scan1_nv_end", Nvalid, 1'b0);
      check("scan1_upd", n_upd, 1);
      check("scan1_prsd", Prsd, 16'h786D);
      check("scan1_lf", LinkFail, 1'b0);
      run_frame(20000, 8, -1);
      compare_frame("scan2", 8'd2);
      check("scan2_nv_start", nv_start, 1'b0);
      check("scan2_rst", n_rst, 0);
      phy_word = 16'h0004;
      run_frame(20000, -1, -1);
      ScanStat = 1'b0;
      compare_frame("scan_rd", 8'd2);
      check("scan_rd_rst", n_rst, 1);
      check("scan_rd_prsd", Prsd, 16'h0004);
      check("scan_rd_lf", LinkFail, 1'b0);
      repeat (20) @(negedge Clk_reg);
      check("scan_off_busy", Busy, 1'b0);
      check("scan_off_nv", Nvalid, 1'b0);
`else
      ScanStat = 1'b1;
      p = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge Clk_reg);
         if (Busy || Nvalid) p++;
      end
      check("scan_ignored", p, 0);
      ScanStat = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/miim_master.md
Name: miim_master

Overview:
- MII management (MDC/MDIO) master for the ecatmac block.
- Sits directly downstream of the MAC host register file. It consumes Divider, CtrlData, Rgad, Fiad, NoPre, WCtrlData, RStat and ScanStat.
- It returns Busy, LinkFail, Nvalid, Prsd, WCtrlDataStart, RStatStart and UpdateMIIRX_DATAReg to that register file.
- Serialises IEEE 802.3 clause-22 write and read frames to the external PHY.

Parameters:
- PRE_LEN, 32, preamble length in MDC bits (all ones), sent when NoPre=0.
- MIN_DIV, 2, minimum effective divider; smaller Divider values are clamped to this.

Ports:
- Clk_reg  in  1  register/host clock, sole clock of the block
- Reset  in  1  synchronous active-high reset
- Divider  in  8  Clk_reg cycles per MDC period
- CtrlData  in  16  write data to PHY
- Rgad  in  5  PHY register address
- Fiad  in  5  PHY address
- NoPre  in  1  1 = suppress preamble
- WCtrlData  in  1  write command request (level)
- RStat  in  1  read command request (level)
- ScanStat  in  1  continuous scan-read request (level)
- Mdi  in  1  MDIO input from pad
- Mdc  out  1  management clock
- Mdo  out  1  MDIO output data
- MdoEn  out  1  MDIO output enable (1 = drive)
- Busy  out  1  frame in progress
- WCtrlDataStart  out  1  one-cycle pulse: write accepted, clears WCtrlData bit upstream
- RStatStart  out  1  one-cycle pulse: read accepted, clears RStat bit upstream
- UpdateMIIRX_DATAReg  out  1  one-cycle pulse: Prsd valid, load read-data register
- Prsd  out  16  last read data
- LinkFail  out  1  link-fail status from PHY status register bit 2
- Nvalid  out  1  scan result not yet valid

Behaviour:
- Clock and reset: one clock, Clk_reg; reset is synchronous and active-high on Reset.
- Reset values:
  - Mdc=0, Mdo=0, MdoEn=0, Busy=0, Prsd=0, LinkFail=0, Nvalid=0.
  - All pulses 0; state IDLE.
  - Reset asserted mid-frame aborts the frame immediately. No pulses are emitted.
- MDC generation:
  - eff_div = max(Divider, MIN_DIV), with the LSB forced to 0.
  - A half-period counter counts 0..eff_div/2-1. Mdc toggles when the counter wraps.
  - rise_tick / fall_tick are one-cycle internal strobes coincident with the Mdc 0->1 / 1->0 toggles.
  - Mdc runs continuously, including in IDLE.
  - A Divider change takes effect at the next counter wrap.
- MDIO timing:
  - Mdo and MdoEn update only on fall_tick.
  - Mdi is sampled on rise_tick.
- States: IDLE, PRE, ST_OP, ADDR, TA, DATA.
  - A 6-bit bit counter indexes bits within each state.
- Start (IDLE only, evaluated on fall_tick), priority write > read > scan:
  - WCtrlData=1: start a write. WCtrlDataStart pulses in that cycle.
  - else RStat=1: start a read. RStatStart pulses in that cycle.
  - else ScanStat=1: start a scan read. No Start pulse.
  - On start, Busy=1 and Fiad/Rgad/CtrlData/NoPre/op are latched.
  - Later input changes do not affect the frame in flight.
- Frame sequence:
  - PRE: PRE_LEN ones, skipped if NoPre=1.
  - ST_OP: 01, then 01 (write) or 10 (read).
  - ADDR: Fiad then Rgad, MSB first.
  - TA:
    - Write: drive 10.
    - Read: MdoEn=0 for both TA bits.
  - DATA:
    - Write: CtrlData MSB first.
    - Read: 16 Mdi samples shifted MSB first.
  - MdoEn=1 from PRE through write DATA. For reads, MdoEn=0 from TA through DATA.
- End of frame, at the fall_tick after the last data bit:
  - MdoEn=0, Mdo=0, return to IDLE.
  - Busy deasserts in the same cycle.
  - A new start is not evaluated until the next fall_tick.
- Read/scan completion:
  - Prsd is loaded with the shift register.
  - UpdateMIIRX_DATAReg pulses in the same cycle.
  - If the latched Rgad==1: LinkFail <= ~data[2].
- Nvalid:
  - Set in the cycle a scan starts, if this is the first scan since ScanStat rose.
  - Cleared at the first scan completion.
  - Forced to 0 whenever ScanStat=0 in IDLE.
- Scan repeat: while ScanStat stays 1, scan reads repeat back-to-back. A pending write or read still wins at each IDLE start.
- Latency, write with NoPre=0: 64 MDC periods from start to Busy fall.

Optional Feature:
- Macro: MIIM_SCAN_EN.
- Defined: scan behaviour as above.
- Undefined:
  - ScanStat is ignored; Nvalid is tied 0.
  - LinkFail updates only on explicit RStat reads of register 1.

Test Plan:
- Divider=8, NoPre=0, Fiad=5'h02, Rgad=5'h01, CtrlData=16'hA5C3, WCtrlData=1:
  - WCtrlDataStart is a single pulse.
  - Mdo shows 32 ones, then 0101 00010 00001 10 1010010111000011.
  - Busy lasts 64 MDC periods; Mdc period = 8 Clk_reg cycles.
- Divider=1: Mdc period = 2 Clk_reg cycles (clamp).
- NoPre=1, RStat=1, Rgad=1, PHY model drives 16'h7849:
  - MdoEn=0 during TA and DATA.
  - Prsd=16'h7849; UpdateMIIRX_DATAReg pulses once.
  - LinkFail=1 (bit2=0).
  - Frame = 32 MDC periods.
- ScanStat=1, Rgad=1, PHY returns 16'h786D:
  - Nvalid=1 until the first completion, then 0.
  - LinkFail=0; scans repeat.
  - Set RStat=1 mid-scan: it starts after the current scan ends.
- WCtrlData and RStat both 1 in IDLE:
  - Write first; RStatStart is absent until the write ends.
  - Then the read starts and RStatStart pulses.
- Reset asserted at bit 20 of a write:
  - Next cycle: Busy=0, MdoEn=0, Mdc=0, no Start/Update pulses.
  - After reset, a fresh write completes normally.
